// File: rtl/bp_pkg.sv
// Shared branch-predictor constants: default table geometry and the
// saturating-counter reset/limit values as functions of counter width.
package bp_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_GHR_BITS   = 6;
    localparam int DEF_CTR_BITS   = 2;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic int WEAK_NT(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic int CTR_MAX(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

endpackage

// File: rtl/pht_counter_update.sv
// Saturating up/down step for one pattern-table counter.
module pht_counter_update
    import bp_pkg::*;
#(
    parameter int CTR_BITS = DEF_CTR_BITS
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] MAX_V = CTR_BITS'(CTR_MAX(CTR_BITS));
    localparam logic [CTR_BITS-1:0] ONE_V = CTR_BITS'(1);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != MAX_V) ctr_o = ctr_i + ONE_V;
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - ONE_V;
        end
    end

endmodule

// File: rtl/gshare_pattern_table.sv
// Pattern history table with bimodal/gshare indexing, same-cycle prediction,
// resolution-time training, and branch/mispredict performance counters.
module gshare_pattern_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int CTR_BITS   = DEF_CTR_BITS,
    parameter int GHR_BITS   = DEF_GHR_BITS,
    parameter int GSHARE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pred_pc_i,
    output logic                  pred_taken_o,
    output logic [INDEX_BITS-1:0] pred_index_o,
    input  logic                  upd_valid_i,
    input  logic [INDEX_BITS-1:0] upd_index_i,
    input  logic                  upd_taken_i,
    input  logic                  upd_mispredict_i,
    output logic [GHR_BITS-1:0]   ghr_out_o,
    output logic [31:0]           branch_count_o,
    output logic [31:0]           mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(WEAK_NT(CTR_BITS));

    logic [CTR_BITS-1:0]   pht_q [ENTRIES];
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [31:0]           branch_count_q, mispredict_count_q;
    logic [INDEX_BITS-1:0] pc_idx;
    logic [CTR_BITS-1:0]   upd_ctr, upd_ctr_next;
    logic                  bypass_hit;
    logic                  unused_pc_bits;

    assign pc_idx         = pred_pc_i[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{pred_pc_i[31:INDEX_BITS+2], pred_pc_i[1:0]};

    generate
        if (GSHARE != 0) begin : g_gshare
            assign pred_index_o = pc_idx ^ INDEX_BITS'(ghr_q);
        end else begin : g_bimodal
            assign pred_index_o = pc_idx;
        end

        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_d = upd_taken_i;
        end else begin : g_ghrn
            assign ghr_d = {ghr_q[GHR_BITS-2:0], upd_taken_i};
        end
    endgenerate

    // One step unit serves both the table write and the read bypass.
    assign upd_ctr = pht_q[upd_index_i];

    pht_counter_update #(.CTR_BITS(CTR_BITS)) u_step (
        .ctr_i   (upd_ctr),
        .taken_i (upd_taken_i),
        .ctr_o   (upd_ctr_next)
    );

    assign bypass_hit   = upd_valid_i && !rst && (upd_index_i == pred_index_o);
    assign pred_taken_o = bypass_hit ? upd_ctr_next[CTR_BITS-1]
                                     : pht_q[pred_index_o][CTR_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (upd_valid_i) begin
            pht_q[upd_index_i] <= upd_ctr_next;
            ghr_q              <= ghr_d;
            if (branch_count_q != '1) branch_count_q <= branch_count_q + 32'd1;
            if (upd_mispredict_i && (mispredict_count_q != '1))
                mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end

    assign ghr_out_o          = ghr_q;
    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Directed bench: one bimodal and one gshare instance share all inputs, so
// their tables and history stay identical and only the index differs.
module tb_gshare_pattern_table;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] predPc;
    logic        updValid, updTaken, updMispredict;
    logic [5:0]  updIndex;

    logic        biTaken, gsTaken;
    logic [5:0]  biIndex, gsIndex, biGhr, gsGhr;
    logic [31:0] biBranch, gsBranch, biMisp, gsMisp;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    gshare_pattern_table #(.INDEX_BITS(6), .CTR_BITS(2), .GHR_BITS(6), .GSHARE(0)) dutBi (
        .clk(clk), .rst(rst), .pred_pc_i(predPc), .pred_taken_o(biTaken),
        .pred_index_o(biIndex), .upd_valid_i(updValid), .upd_index_i(updIndex),
        .upd_taken_i(updTaken), .upd_mispredict_i(updMispredict),
        .ghr_out_o(biGhr), .branch_count_o(biBranch), .mispredict_count_o(biMisp)
    );

    gshare_pattern_table #(.INDEX_BITS(6), .CTR_BITS(2), .GHR_BITS(6), .GSHARE(1)) dutGs (
        .clk(clk), .rst(rst), .pred_pc_i(predPc), .pred_taken_o(gsTaken),
        .pred_index_o(gsIndex), .upd_valid_i(updValid), .upd_index_i(updIndex),
        .upd_taken_i(updTaken), .upd_mispredict_i(updMispredict),
        .ghr_out_o(gsGhr), .branch_count_o(gsBranch), .mispredict_count_o(gsMisp)
    );

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        um;
        logic        expTaken;
        logic [5:0]  expGhr;
        logic [31:0] expBranch;
        logic [31:0] expMisp;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic uv, input logic [5:0] ui,
                                 input logic ut, input logic um);
        predPc        = pc;
        updValid      = uv;
        updIndex      = ui;
        updTaken      = ut;
        updMispredict = um;
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(32'h14, 1'b0, 6'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 6'b000001, 32'd1,  32'd0};
        vecs[1]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 6'b000011, 32'd2,  32'd0};
        vecs[2]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 6'b000111, 32'd3,  32'd0};
        vecs[3]  = '{32'h14, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1, 6'b001110, 32'd4,  32'd1};
        vecs[4]  = '{32'h14, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 6'b011100, 32'd5,  32'd1};
        vecs[5]  = '{32'h14, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0, 6'b111000, 32'd6,  32'd2};
        vecs[6]  = '{32'h14, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 6'b110000, 32'd7,  32'd2};
        vecs[7]  = '{32'h14, 1'b0, 6'd5, 1'b1, 1'b1, 1'b0, 6'b110000, 32'd7,  32'd2};
        vecs[8]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 6'b100001, 32'd8,  32'd3};
        vecs[9]  = '{32'h08, 1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 6'b000011, 32'd9,  32'd3};
        vecs[10] = '{32'h24, 1'b1, 6'd2, 1'b0, 1'b1, 1'b1, 6'b000110, 32'd10, 32'd4};
        vecs[11] = '{32'h08, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0, 6'b000110, 32'd10, 32'd4};

        rst = 1'b1;
        applyStimulus(32'h14, 1'b0, 6'd5, 1'b0, 1'b0);
        #3;
        checkOutput("reset pred_taken",  {31'd0, biTaken}, 32'd0);
        checkOutput("reset ghr",         {26'd0, biGhr},   32'd0);
        checkOutput("reset branch",      biBranch,         32'd0);
        checkOutput("reset mispredict",  biMisp,           32'd0);
        nextCycle();
        rst = 1'b0;
        #1;

        // Saturation, bypass on the same index, and perf counting.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut, vecs[i].um);
            #1;
            checkOutput($sformatf("vec%0d pred_taken", i), {31'd0, biTaken}, {31'd0, vecs[i].expTaken});
            nextCycle();
            checkOutput($sformatf("vec%0d ghr", i),        {26'd0, biGhr}, {26'd0, vecs[i].expGhr});
            checkOutput($sformatf("vec%0d branch", i),     biBranch, vecs[i].expBranch);
            checkOutput($sformatf("vec%0d mispredict", i), biMisp,   vecs[i].expMisp);
        end
        checkOutput("gshare ghr tracks", {26'd0, gsGhr}, 32'b000110);

        // Bypass: counter[3] still weak-NT; a taken update flips the prediction now.
        applyStimulus(32'h0C, 1'b0, 6'd3, 1'b1, 1'b0);
        #1;
        checkOutput("bypass before", {31'd0, biTaken}, 32'd0);
        applyStimulus(32'h0C, 1'b1, 6'd3, 1'b1, 1'b0);
        #1;
        checkOutput("bypass same cycle", {31'd0, biTaken}, 32'd1);
        nextCycle();
        applyStimulus(32'h0C, 1'b0, 6'd3, 1'b0, 1'b0);
        #1;
        checkOutput("bypass written", {31'd0, biTaken}, 32'd1);

        // Gshare indexing after history 1,0,1.
        doReset();
        checkOutput("rereset ghr", {26'd0, gsGhr}, 32'd0);
        applyStimulus(32'h0, 1'b1, 6'd0, 1'b1, 1'b0); nextCycle();
        applyStimulus(32'h0, 1'b1, 6'd0, 1'b0, 1'b0); nextCycle();
        applyStimulus(32'h0, 1'b1, 6'd0, 1'b1, 1'b0); nextCycle();
        applyStimulus(32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        checkOutput("gshare ghr", {26'd0, gsGhr},   32'b000101);
        checkOutput("gshare index", {26'd0, gsIndex}, 32'd21);
        checkOutput("bimodal index", {26'd0, biIndex}, 32'd16);

        // Asynchronous reset between edges discards training at once.
        doReset();
        applyStimulus(32'h14, 1'b1, 6'd5, 1'b1, 1'b0); nextCycle();
        applyStimulus(32'h14, 1'b1, 6'd5, 1'b1, 1'b0); nextCycle();
        applyStimulus(32'h14, 1'b0, 6'd5, 1'b0, 1'b0);
        #1;
        checkOutput("trained pred_taken", {31'd0, biTaken}, 32'd1);
        checkOutput("trained branch",     biBranch,         32'd2);
        #1 rst = 1'b1;
        #1;
        checkOutput("async pred_taken", {31'd0, biTaken}, 32'd0);
        checkOutput("async ghr",        {26'd0, biGhr},   32'd0);
        checkOutput("async branch",     biBranch,         32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post reset pred_taken", {31'd0, biTaken}, 32'd0);
        nextCycle();
        applyStimulus(32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
        #1;
        checkOutput("post reset weak_nt step", {31'd0, biTaken}, 32'd1);
        nextCycle();
        applyStimulus(32'h14, 1'b0, 6'd5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/gshare_pattern_table.md
Name: gshare_pattern_table

Overview:
- Parametrised pattern history table (PHT) of N-bit saturating counters for the branch target buffer front end.
- Provides a same-cycle taken/not-taken prediction for the fetch PC and trains counters on branch resolution from EX.
- Runs in bimodal mode (PC index) or gshare mode (PC XOR global history).
- Keeps branch and mispredict counters for the benchmarking framework.

Parameters:
- INDEX_BITS, 6, log2 of PHT entries (64).
- CTR_BITS, 2, counter width; legal range 2..4.
- GHR_BITS, 6, global history length; must be 1..INDEX_BITS.
- GSHARE, 1, 1 = index is PC XOR GHR; 0 = bimodal, index is PC only.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pred_pc  in  32  fetch PC.
- pred_taken  out  1  prediction, combinational.
- pred_index  out  INDEX_BITS  index used; carried down the pipe to EX.
- upd_valid  in  1  resolved conditional branch this cycle.
- upd_index  in  INDEX_BITS  pred_index carried with that branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  the prediction for this branch was wrong; qualified by upd_valid.
- ghr_out  out  GHR_BITS  current global history, for debug.
- branch_count  out  32  resolved branches.
- mispredict_count  out  32  mispredictions.

Behaviour:
- Storage: 2^INDEX_BITS counters of CTR_BITS each, plus a GHR_BITS global history register (GHR), both flopped.
- Reset (async, rst=1):
  - every counter = WEAK_NT = 2^(CTR_BITS-1)-1 (2'b01 at default);
  - GHR = 0; both perf counters = 0.
  - Reset mid-operation discards all training immediately.
  - While rst=1, pred_taken reflects the reset contents (0).
- Index:
  - pc_idx = pred_pc[INDEX_BITS+1:2].
  - pred_index = pc_idx XOR zero-extended GHR when GSHARE=1, else pc_idx.
- Prediction:
  - pred_taken = MSB of counter[pred_index], combinational, zero latency, no enable.
  - It always uses the GHR value currently in the register.
- Training, on a rising clk edge with upd_valid=1:
  - upd_taken=1: counter[upd_index] += 1, saturating at CTR_MAX = 2^CTR_BITS-1.
  - upd_taken=0: counter[upd_index] -= 1, saturating at 0.
  - No wrap-around in either direction.
  - GHR <= {GHR[GHR_BITS-2:0], upd_taken}; for GHR_BITS=1, GHR <= upd_taken.
  - branch_count += 1.
  - mispredict_count += 1 if upd_mispredict=1.
  - Both perf counters saturate at 32'hFFFF_FFFF.
- GHR is updated non-speculatively, at resolution only. No checkpoint or repair is required.
- Same-cycle read and update:
  - If upd_valid=1 and upd_index == pred_index, pred_taken is bypassed to the MSB of the post-update counter value.
  - pred_index itself still uses the pre-update GHR.
- upd_valid=0: no state changes. upd_taken and upd_mispredict are ignored.
- upd_mispredict affects only the perf counter. Counter training depends solely on upd_taken.
- Only one update per cycle. Exactly one counter changes per update; all other entries are untouched.

Decomposition:
- Shared package bp_pkg holds:
  - localparam functions/constants WEAK_NT(CTR_BITS) and CTR_MAX(CTR_BITS);
  - the default INDEX_BITS/GHR_BITS values.
- One combinational sub-module, pht_counter_update:
  - inputs: ctr, taken;
  - output: the saturating next counter value;
  - parametrised by CTR_BITS.
  - It is used for both the write path and the bypass path.

Test Plan:
- Reset check: assert rst with any pred_pc -> pred_taken=0, ghr_out=0, both counts 0; counter[5] reads 2'b01.
- Saturation:
  - bimodal (GSHARE=0), upd_index=5, three updates with upd_taken=1 -> counter 01->10->11->11; pred_taken=1 for pred_pc=0x14 from the 1st update on.
  - then three with upd_taken=0 -> 11->10->01->00, never below 0.
- Bypass: counter[3]=01, pred_pc=0x0C with upd_valid=1, upd_index=3, upd_taken=1 in the same cycle -> pred_taken=1 in that cycle.
- Gshare indexing: GSHARE=1, apply updates with taken=1,0,1 -> ghr_out=6'b000101; then pred_pc=0x40 (pc_idx=16) -> pred_index=21.
- Perf counters: 10 updates with upd_mispredict asserted on 4 of them -> branch_count=10, mispredict_count=4; upd_mispredict=1 with upd_valid=0 -> no change.
- Async reset mid-training: pulse rst between clk edges after training counter[5] to 11 -> counter[5]=01, GHR=0 immediately, without waiting for a clk edge.
